// File: rtl/core_seq.sv
// core_seq: multi-cycle sequencer for the RV32I core.
//
// Steps each instruction through FETCH, DECODE, EXECUTE, optional MEM and
// WB. The single memory port is shared between instruction fetch
// (addr_sel=0) and load/store (addr_sel=1). Decoder outputs are turned into
// per-cycle enables for PC, IR, MDR, ALU register and register file.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   run               allows new fetches; sampled only in IDLE and WB
//   mem, mem_read     decoder: data access / access is a load
//   branch, wb        decoder: branch or jump / writeback code (nonzero = write rd)
//   take              datapath branch result, valid in EXECUTE (1 for jumps)
//   mem_ready         memory completes the current request this cycle
//   mem_req, mem_we   memory request and write strobe
//   addr_sel          memory address source: 0 = PC, 1 = ALU result
//   ir_en, mdr_en     load instruction register / memory data register
//   alu_en, rf_we     capture ALU result / register file write
//   pc_en, pc_sel     update PC / next-PC source: 0 = PC+4, 1 = ALU target
//   retire, instret   completion pulse / retired-instruction count
//   state             current FSM state, for debug
//
// Memory handshake: a transfer completes on the rising edge where mem_req
// and mem_ready are both 1; mem_req, addr_sel and mem_we hold steady until
// then, and mem_ready is ignored whenever mem_req is 0.

module core_seq #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        mem,
   input  logic        mem_read,
   input  logic        branch,
   input  logic [1:0]  wb,
   input  logic        take,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        addr_sel,
   output logic        ir_en,
   output logic        mdr_en,
   output logic        alu_en,
   output logic        rf_we,
   output logic        pc_en,
   output logic        pc_sel,
   output logic        retire,
   output logic [31:0] instret,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      DECODE  = 3'd2,
      EXECUTE = 3'd3,
      MEM     = 3'd4,
      WB      = 3'd5
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [31:0] instret_q;

   // Decoder outputs come from the IR and are only trusted up to EXECUTE,
   // so everything used later is captured there.
   logic        take_q;
   logic        mem_q;
   logic        mem_read_q;
   logic [1:0]  wb_q;

   // The PC reset value is applied by the datapath; it is carried here so the
   // core's parameter set stays in one place.
   logic        unused_reset_pc;
   assign unused_reset_pc = ^RESET_PC;

   assign state   = state_q;
   assign instret = instret_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         instret_q  <= 32'd0;
         take_q     <= 1'b0;
         mem_q      <= 1'b0;
         mem_read_q <= 1'b0;
         wb_q       <= 2'b00;
      end else begin
         state_q <= state_d;
         if (state_q == EXECUTE) begin
            take_q     <= branch & take;
            mem_q      <= mem;
            mem_read_q <= mem_read;
            wb_q       <= wb;
         end
         // Wraps naturally from 32'hFFFF_FFFF to 0.
         if (state_q == WB) begin
            instret_q <= instret_q + 32'd1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_en    = 1'b0;
      mdr_en   = 1'b0;
      alu_en   = 1'b0;
      rf_we    = 1'b0;
      pc_en    = 1'b0;
      pc_sel   = 1'b0;
      retire   = 1'b0;
      case (state_q)
         IDLE: begin
            if (run) state_d = FETCH;
         end
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_en   = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            state_d = EXECUTE;
         end
         EXECUTE: begin
            alu_en  = 1'b1;
            // Live decoder input: the latched copy is not valid until the edge.
            state_d = mem ? MEM : WB;
         end
         MEM: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = mem_q & ~mem_read_q;
            if (mem_ready) begin
               mdr_en  = mem_read_q;
               state_d = WB;
            end
         end
         WB: begin
            rf_we   = |wb_q;
            pc_en   = 1'b1;
            pc_sel  = take_q;
            retire  = 1'b1;
            state_d = run ? FETCH : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_core_seq.sv
module tb_core_seq;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        mem;
   logic        mem_read;
   logic        branch;
   logic [1:0]  wb;
   logic        take;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        addr_sel;
   logic        ir_en;
   logic        mdr_en;
   logic        alu_en;
   logic        rf_we;
   logic        pc_en;
   logic        pc_sel;
   logic        retire;
   logic [31:0] instret;
   logic [2:0]  state;

   core_seq dut (
      .clk(clk), .rst_n(rst_n), .run(run), .mem(mem), .mem_read(mem_read),
      .branch(branch), .wb(wb), .take(take), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_en(ir_en),
      .mdr_en(mdr_en), .alu_en(alu_en), .rf_we(rf_we), .pc_en(pc_en),
      .pc_sel(pc_sel), .retire(retire), .instret(instret), .state(state)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   // Expected vector: {mem_req, mem_we, addr_sel, ir_en, mdr_en, alu_en,
   //                   rf_we, pc_en, pc_sel, retire, state[2:0], instret[31:0]}
   logic [44:0] exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] cnt = 32'd0;   // model retired-instruction count
   int          cyc = 0;
   int          fstart = 0;
   int          last_lat = 0;
   logic [2:0]  prev_st = 3'd0;

   function automatic logic [9:0] fl(input logic mreq, input logic mwe, input logic asel,
                                     input logic ir, input logic mdr, input logic alu,
                                     input logic rf, input logic pce, input logic pcs,
                                     input logic ret);
      return {mreq, mwe, asel, ir, mdr, alu, rf, pce, pcs, ret};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
      end
   endtask

   initial begin : compare
      logic [44:0] e;
      logic [44:0] act;
      forever begin
         @(negedge clk);
         cyc++;
         if (state == 3'd1 && prev_st != 3'd1) fstart = cyc;
         if (retire === 1'b1) last_lat = cyc - fstart + 1;
         prev_st = state;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {mem_req, mem_we, addr_sel, ir_en, mdr_en, alu_en,
                   rf_we, pc_en, pc_sel, retire, state, instret};
            n_cmp++;
            if (act !== e) begin
               n_bad++;
               $display("FAIL cycle_cmp t=%0t flags got=%b exp=%b state got=%0d exp=%0d instret got=%h exp=%h",
                        $time, act[44:35], e[44:35], act[34:32], e[34:32], act[31:0], e[31:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] st, input logic [9:0] f);
      exp_q.push_back({f, st, cnt});
   endtask

   // Values on decoder/memory inputs that the sequencer must ignore this cycle.
   task automatic rnd_dec();
      mem       = 1'($urandom);
      mem_read  = 1'($urandom);
      branch    = 1'($urandom);
      take      = 1'($urandom);
      wb        = 2'($urandom);
      mem_ready = 1'($urandom);
      run       = 1'($urandom);
   endtask

   // n cycles parked with run=0, then one cycle raising run.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step(); rnd_dec(); run = 1'b0; push(3'd0, 10'd0);
      end
      step(); rnd_dec(); run = 1'b1; push(3'd0, 10'd0);
   endtask

   // kind: 0 ALU, 1 load, 2 store, 3 branch, 4 jump.
   // fw/mw: wait cycles before mem_ready in fetch / data access.
   // ra: run value in WB. rst_mem: pulse reset during the first data-access cycle.
   task automatic run_instr(input int kind, input logic [1:0] wbv, input logic tk,
                            input int fw, input int mw, input logic ra, input logic rst_mem);
      logic is_mem, is_ld, br, tk_eff;
      is_mem = (kind == 1) || (kind == 2);
      is_ld  = (kind == 1);
      br     = (kind >= 3);
      tk_eff = br && ((kind == 4) || tk);
      for (int i = 0; i <= fw; i++) begin
         step(); rnd_dec(); mem_ready = (i == fw);
         push(3'd1, fl(1'b1, 1'b0, 1'b0, (i == fw), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      step(); rnd_dec(); push(3'd2, 10'd0);
      step(); rnd_dec();
      mem = is_mem; mem_read = is_ld; branch = br; wb = wbv;
      take = (kind == 4) ? 1'b1 : tk;
      push(3'd3, fl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      if (is_mem) begin
         for (int i = 0; i <= mw; i++) begin
            step(); rnd_dec();
            mem_ready = rst_mem ? 1'b0 : (i == mw);
            push(3'd4, fl(1'b1, !is_ld, 1'b1, 1'b0, is_ld && (i == mw) && !rst_mem,
                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            if (rst_mem) begin
               @(negedge clk);
               #2;
               rst_n = 1'b0;
               #1;
               chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
               chk("rst_state", {29'd0, state}, 32'd0);
               chk("rst_instret", instret, 32'd0);
               chk("rst_flags", {22'd0, mem_we, addr_sel, ir_en, mdr_en, alu_en,
                                 rf_we, pc_en, pc_sel, retire, 1'b0}, 32'd0);
               cnt = 32'd0;
               run = 1'b0;
               step();
               @(negedge clk);
               #2;
               rst_n = 1'b1;
               return;
            end
         end
      end
      step(); rnd_dec(); run = ra;
      push(3'd5, fl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (wbv != 2'd0), 1'b1, tk_eff, 1'b1));
      cnt = cnt + 32'd1;
   endtask

   // Sets the counter just before wrap during an IDLE cycle.
   task automatic preload();
      step();
      force dut.instret_q = 32'hFFFF_FFFF;
      #1;
      release dut.instret_q;
      cnt = 32'hFFFF_FFFF;
      rnd_dec(); run = 1'b0;
      push(3'd0, 10'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      int kind;
      logic ra;
      rst_n = 1'b0;
      rnd_dec();
      run = 1'b1;
      #13;
      chk("reset_state", {29'd0, state}, 32'd0);
      chk("reset_instret", instret, 32'd0);
      chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
      chk("reset_outputs", {22'd0, mem_req, mem_we, addr_sel, ir_en, mdr_en, alu_en,
                            rf_we, pc_en, pc_sel, retire}, 32'd0);
      #4;
      run = 1'b0;
      rst_n = 1'b1;

      // Back-to-back ADDs with zero-wait memory.
      idle(1);
      run_instr(0, 2'b10, 1'b0, 0, 0, 1'b1, 1'b0);
      @(negedge clk); #1;
      chk("add_latency", last_lat, 32'd4);
      run_instr(0, 2'b10, 1'b0, 0, 0, 1'b1, 1'b0);
      run_instr(0, 2'b10, 1'b0, 0, 0, 1'b0, 1'b0);
      idle(0);
      chk("instret_after_3", instret, 32'd3);

      // Load with two wait cycles in both fetch and data access.
      run_instr(1, 2'b01, 1'b0, 2, 2, 1'b0, 1'b0);
      @(negedge clk); #1;
      chk("load_latency", last_lat, 32'd9);
      idle(1);

      // Store, taken branch, not-taken branch, jump.
      run_instr(2, 2'b00, 1'b0, 0, 1, 1'b1, 1'b0);
      run_instr(3, 2'b00, 1'b1, 1, 0, 1'b1, 1'b0);
      run_instr(3, 2'b00, 1'b0, 0, 0, 1'b1, 1'b0);
      run_instr(4, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0);
      idle(2);

      // Randomized instruction mix.
      for (int n = 0; n < 150; n++) begin
         kind = $urandom_range(0, 4);
         ra = ($urandom_range(0, 3) != 0);
         run_instr(kind, 2'($urandom), 1'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), ra, 1'b0);
         if (!ra) idle($urandom_range(0, 2));
      end

      // Counter wrap.
      run_instr(0, 2'b11, 1'b0, 0, 0, 1'b0, 1'b0);
      preload();
      idle(0);
      run_instr(0, 2'b11, 1'b0, 0, 0, 1'b0, 1'b0);
      idle(0);
      chk("instret_wrap", instret, 32'd0);

      // Asynchronous reset in the middle of a data access.
      run_instr(0, 2'b01, 1'b0, 0, 0, 1'b1, 1'b0);
      run_instr(1, 2'b01, 1'b0, 0, 3, 1'b0, 1'b1);
      idle(1);
      run_instr(0, 2'b01, 1'b0, 1, 0, 1'b0, 1'b0);
      idle(0);
      chk("instret_after_reset", instret, 32'd1);

      repeat (3) @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
